sap1_control_unit: RTL and testbench

SAP1_CONTROL_UNIT -- requirements
Module: sap1_control_unit

---
 rtl/sap1_control_unit.sv | 120 ++++++++++++
 tb/tb_sap1_control_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sap1_control_unit.sv
// SAP-1 control sequencer: six-state T-counter clocked on the falling edge,
// decoded control word, gated datapath clock and a combinational add/sub unit.
module sap1_control_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  clk_out,
  output logic [11:0]           ctrl,
  output logic [2:0]            stage,
  output logic [DATA_WIDTH-1:0] adder_out
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bit positions inside the control word, MSB first.
  localparam int HLT       = 11;
  localparam int PC_INC    = 10;
  localparam int PC_EN     = 9;
  localparam int MAR_LOAD  = 8;
  localparam int MEM_EN    = 7;
  localparam int IR_LOAD   = 6;
  localparam int IR_EN     = 5;
  localparam int A_LOAD    = 4;
  localparam int A_EN      = 3;
  localparam int B_LOAD    = 2;
  localparam int ADDER_SUB = 1;
  localparam int ADDER_EN  = 0;

  logic hlt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    ctrl = '0;
    case (stage)
      T0: begin
        ctrl[PC_EN]    = 1'b1;
        ctrl[MAR_LOAD] = 1'b1;
      end
      T1: ctrl[PC_INC] = 1'b1;
      T2: begin
        ctrl[MEM_EN]  = 1'b1;
        ctrl[IR_LOAD] = 1'b1;
      end
      T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl[IR_EN]    = 1'b1;
            ctrl[MAR_LOAD] = 1'b1;
          end
          OP_HLT:  ctrl[HLT] = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            ctrl[MEM_EN] = 1'b1;
            ctrl[A_LOAD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[MEM_EN] = 1'b1;
            ctrl[B_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_ADD: begin
            ctrl[ADDER_EN] = 1'b1;
            ctrl[A_LOAD]   = 1'b1;
          end
          OP_SUB: begin
            ctrl[ADDER_SUB] = 1'b1;
            ctrl[ADDER_EN]  = 1'b1;
            ctrl[A_LOAD]    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign hlt = ctrl[HLT];

  // Falling-edge counter: the datapath captures on the rising edge of clk_out,
  // so control settles half a cycle ahead. Halt freezes the count until reset;
  // any out-of-range value folds back to T0.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stage <= T0;
    end else if (!hlt) begin
      stage <= (stage >= T5) ? T0 : stage + 3'd1;
    end
  end

  // hlt only moves while clk is low, so this AND never produces a runt pulse.
  assign clk_out = clk & ~hlt;

  // Always computed; adder_en merely requests the bus.
  assign adder_out = ctrl[ADDER_SUB] ? (a_in - b_in) : (a_in + b_in);

endmodule

// File: tb/tb_sap1_control_unit.sv
// Self-checking bench for sap1_control_unit: per-stage expectations are queued
// when an instruction is issued and popped after each falling clock edge.
module tb_sap1_control_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        clk_out;
  logic [11:0] ctrl;
  logic [2:0]  stage;
  logic [7:0]  adder_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  stage;
    logic [11:0] ctrl;
    logic [7:0]  sum;
    bit          chk_sum;
  } exp_t;

  exp_t sb[$];

  sap1_control_unit #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .a_in      (a_in),
    .b_in      (b_in),
    .clk_out   (clk_out),
    .ctrl      (ctrl),
    .stage     (stage),
    .adder_out (adder_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [11:0] c,
                      input logic [7:0] sum, input bit chk);
    exp_t e;
    e.stage = s; e.ctrl = c; e.sum = sum; e.chk_sum = chk;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s_stage_t%0d", tag, e.stage), stage, e.stage);
    check($sformatf("%s_ctrl_t%0d", tag, e.stage), ctrl, e.ctrl);
    if (e.chk_sum)
      check($sformatf("%s_sum_t%0d", tag, e.stage), adder_out, e.sum);
  endtask

  task automatic edge_check(input string tag);
    @(negedge clk);
    #1;
    pop_check(tag);
  endtask

  // Called with the counter at T0; runs one full instruction and the wrap to T0.
  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [11:0] c3, input logic [11:0] c4,
                           input logic [11:0] c5, input logic [7:0] s4,
                           input logic [7:0] s5, input bit chk);
    opcode = op; a_in = a; b_in = b;
    push(3'd0, 12'h300, 8'h00, 1'b0);
    push(3'd1, 12'h400, 8'h00, 1'b0);
    push(3'd2, 12'h0C0, 8'h00, 1'b0);
    push(3'd3, c3, 8'h00, 1'b0);
    push(3'd4, c4, s4, chk);
    push(3'd5, c5, s5, chk);
    push(3'd0, 12'h300, 8'h00, 1'b0);
    #1;
    pop_check(tag);
    for (int i = 0; i < 6; i++) edge_check(tag);
  endtask

  initial begin
    rst = 1'b0; opcode = 4'h0; a_in = 8'h00; b_in = 8'h00;

    // Held in reset: T0 word, clk_out tracks clk in both phases.
    #1;
    check("rst_stage", stage, 3'd0);
    check("rst_ctrl", ctrl, 12'h300);
    check("rst_clk_out_lo", clk_out, 1'b0);
    #5;
    check("rst_clk_out_hi", clk_out, 1'b1);
    @(negedge clk); #1;
    check("rst_hold_stage", stage, 3'd0);

    @(posedge clk); #1;
    rst = 1'b1;

    run_instr("lda",   4'h0, 8'h00, 8'h00, 12'h120, 12'h090, 12'h000, 8'h00, 8'h00, 1'b0);
    run_instr("add",   4'h1, 8'h05, 8'h03, 12'h120, 12'h084, 12'h011, 8'h08, 8'h08, 1'b1);
    run_instr("sub",   4'h2, 8'h03, 8'h05, 12'h120, 12'h084, 12'h013, 8'h08, 8'hFE, 1'b1);
    run_instr("wrap",  4'h1, 8'hFF, 8'h01, 12'h120, 12'h084, 12'h011, 8'h00, 8'h00, 1'b1);
    run_instr("undef", 4'h7, 8'h10, 8'h20, 12'h000, 12'h000, 12'h000, 8'h30, 8'h30, 1'b1);

    // Reset mid-instruction at T2, then restart from T0.
    opcode = 4'h0;
    push(3'd1, 12'h400, 8'h00, 1'b0);
    push(3'd2, 12'h0C0, 8'h00, 1'b0);
    push(3'd0, 12'h300, 8'h00, 1'b0);
    push(3'd0, 12'h300, 8'h00, 1'b0);
    push(3'd1, 12'h400, 8'h00, 1'b0);
    edge_check("mid");
    edge_check("mid");
    rst = 1'b0; #1;
    pop_check("mid_async");
    @(posedge clk); #1;
    rst = 1'b1;
    pop_check("mid_release");
    edge_check("mid_first");
    repeat (5) @(negedge clk);
    #1;
    push(3'd0, 12'h300, 8'h00, 1'b0);
    pop_check("realign");

    // Halt at T3, stays frozen with clk_out low.
    opcode = 4'hF;
    push(3'd1, 12'h400, 8'h00, 1'b0);
    push(3'd2, 12'h0C0, 8'h00, 1'b0);
    push(3'd3, 12'h800, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) edge_check("hlt");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("hlt_clk_out_%0d", i), clk_out, 1'b0);
      @(negedge clk); #1;
      check($sformatf("hlt_stage_%0d", i), stage, 3'd3);
    end

    // Decode still follows opcode while frozen.
    opcode = 4'h0; #1;
    check("hlt_opchg_ctrl", ctrl, 12'h120);
    opcode = 4'hF; #1;
    check("hlt_reop_ctrl", ctrl, 12'h800);

    rst = 1'b0; #1;
    check("hlt_rst_stage", stage, 3'd0);
    check("hlt_rst_ctrl", ctrl, 12'h300);
    @(posedge clk); #1;
    check("hlt_rst_clk_out_hi", clk_out, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("hlt_rst_clk_out_lo", clk_out, 1'b0);
    check("hlt_rst_first_adv", stage, 3'd1);

    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
